// File: rtl/chi_pkg.sv
// chi_pkg: shared constants and FSM encoding for the chi slice stage.
package chi_pkg;

  localparam int SLICE_W = 25;
  localparam int ROW_W   = 5;
  localparam int LINES   = 64;
  localparam int IDX_W   = 6;

  // 3-bit state encoding; IDLE is 0 so a cleared register means idle.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    READ  = 3'd2,
    LOAD  = 3'd3,
    CAL   = 3'd4,
    WRITE = 3'd5,
    DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/chi_row.sv
// chi_row: combinational chi on one 5-bit row.
//   out[x] = in[x] ^ (~in[(x+1)%5] & in[(x+2)%5])
module chi_row
  import chi_pkg::*;
(
  input  logic [ROW_W-1:0] row_i,
  output logic [ROW_W-1:0] row_o
);

  // Apply the nonlinear row mix bit by bit, wrapping x modulo the row width.
  always_comb begin
    row_o = '0;
    for (int x = 0; x < ROW_W; x++) begin
      row_o[x] = row_i[x] ^ (~row_i[(x + 1) % ROW_W] & row_i[(x + 2) % ROW_W]);
    end
  end

endmodule

// File: rtl/chi_stage.sv
// chi_stage: walks a 64-slice state through chi, one slice at a time.
// Sequence per run: INIT (read_file pulse, counter clear), READ, then
// LOAD -> CAL -> WRITE for each slice, DONE (finish pulse), back to IDLE.
// Optional feature: define CHI_BYPASS_EN to add the chi_bypass input, which
// makes CAL copy the slice register through unchanged.
//
// Handshake: there is no back-pressure. start is a one-cycle request that is
// only honoured in IDLE; read_file, write_file and finish are single-cycle
// strobes, and slice_out/line_index are valid in the cycle write_file is high.
module chi_stage
  import chi_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SLICE_W-1:0] slice_in,
`ifdef CHI_BYPASS_EN
  input  logic               chi_bypass,
`endif
  output logic               read_file,
  output logic [IDX_W-1:0]   line_index,
  output logic               write_file,
  output logic [SLICE_W-1:0] slice_out,
  output logic               finish,
  output logic               busy,
  output logic [2:0]         state_dbg
);

  state_t             state_q;
  logic [IDX_W-1:0]   cnt_q;
  logic [SLICE_W-1:0] slice_q;
  logic [SLICE_W-1:0] out_q;
  logic               read_q;
  logic               write_q;
  logic               finish_q;
  logic               busy_q;

  logic [SLICE_W-1:0] chi_d;
  logic [SLICE_W-1:0] cal_d;

  // Five independent rows; row y occupies bits [5y+4:5y].
  for (genvar y = 0; y < 5; y++) begin : g_row
    chi_row u_row (
      .row_i (slice_q[ROW_W*y +: ROW_W]),
      .row_o (chi_d[ROW_W*y +: ROW_W])
    );
  end

  // Select what CAL stores: chi result, or the raw slice when bypassed.
`ifdef CHI_BYPASS_EN
  always_comb begin
    cal_d = chi_bypass ? slice_q : chi_d;
  end
`else
  always_comb begin
    cal_d = chi_d;
  end
`endif

  // Control FSM plus datapath registers; strobes are registered off the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      slice_q  <= '0;
      out_q    <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      finish_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      finish_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= INIT;
            read_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        INIT: begin
          cnt_q   <= '0;
          state_q <= READ;
        end
        READ: begin
          state_q <= LOAD;
        end
        LOAD: begin
          slice_q <= slice_in;
          state_q <= CAL;
        end
        CAL: begin
          out_q   <= cal_d;
          write_q <= 1'b1;
          state_q <= WRITE;
        end
        WRITE: begin
          // Counter wraps 63 -> 0 naturally in 6 bits.
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == IDX_W'(LINES - 1)) begin
            finish_q <= 1'b1;
            state_q  <= DONE;
          end else begin
            state_q <= LOAD;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign read_file  = read_q;
  assign write_file = write_q;
  assign finish     = finish_q;
  assign busy       = busy_q;
  assign line_index = cnt_q;
  assign slice_out  = out_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_chi_stage.sv
// tb_chi_stage: directed checks of chi_stage timing and data.
// Slice data comes from hand-computed row pairs placed in each row position.
module tb_chi_stage;

  localparam int SW = 25;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [SW-1:0] slice_in;
  logic          read_file;
  logic [5:0]    line_index;
  logic          write_file;
  logic [SW-1:0] slice_out;
  logic          finish;
  logic          busy;
  logic [2:0]    state_dbg;
`ifdef CHI_BYPASS_EN
  logic          chi_bypass = 1'b0;
`endif

  // File model: one slice per line index.
  logic [SW-1:0] mem [64];
  assign slice_in = mem[line_index];

  // Expected slice_out values, in write order.
  logic [SW-1:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Hand-computed chi row pairs.
  logic [4:0] row_in  [8] = '{5'h00, 5'h1F, 5'h02, 5'h04, 5'h01, 5'h08, 5'h10, 5'h03};
  logic [4:0] row_out [8] = '{5'h00, 5'h1F, 5'h12, 5'h05, 5'h09, 5'h0A, 5'h14, 5'h0B};

  chi_stage dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .slice_in   (slice_in),
`ifdef CHI_BYPASS_EN
    .chi_bypass (chi_bypass),
`endif
    .read_file  (read_file),
    .line_index (line_index),
    .write_file (write_file),
    .slice_out  (slice_out),
    .finish     (finish),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // mode 0: all zero; 1: row-pair table; 2: constant 25'h2 passed through unchanged.
  task automatic fill(input int mode);
    logic [SW-1:0] din;
    logic [SW-1:0] dout;
    exp_q.delete();
    for (int l = 0; l < 64; l++) begin
      din  = '0;
      dout = '0;
      if (mode == 1) begin
        for (int y = 0; y < 5; y++) begin
          din[5*y +: 5]  = row_in[(l + y) % 8];
          dout[5*y +: 5] = row_out[(l + y) % 8];
        end
      end else if (mode == 2) begin
        din  = 25'h0000002;
        dout = 25'h0000002;
      end
      mem[l] = din;
      exp_q.push_back(dout);
    end
  endtask

  // Full run from start to finish; spam pulses start randomly during the run.
  task automatic run(input bit spam);
    int  nw;
    bit  done;
    logic [SW-1:0] e;
    nw   = 0;
    done = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= 260 && !done; k++) begin
      if (k == 0) check("read_pulse", read_file, 1);
      else if (read_file) check("read_extra", read_file, 0);
      check("busy_run", busy, 1);
      if (write_file) begin
        check("wr_time", k, 4 + 3 * nw);
        check("wr_index", line_index, nw);
        if (exp_q.size() == 0) check("wr_extra", nw, 64);
        else begin
          e = exp_q.pop_front();
          check("wr_data", slice_out, e);
        end
        nw++;
      end
      if (finish) begin
        check("finish_time", k, 194);
        check("finish_excl", write_file, 0);
        check("write_count", nw, 64);
        check("wrap_index", line_index, 0);
        done = 1;
      end
      if (!done) begin
        start = (spam && k < 185) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
      end
    end
    if (!done) check("finish_timeout", 0, 1);
    start = 1'b0;
    @(negedge clk);
    check("finish_width", finish, 0);
    check("busy_after", busy, 0);
    check("idle_after", state_dbg, 3'd0);
  endtask

  // Abort a run right after the 10th write, then watch that nothing else happens.
  task automatic abort_run();
    int nw;
    int nfin;
    nw   = 0;
    nfin = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 100 && nw < 10; k++) begin
      if (write_file) nw++;
      if (nw < 10) @(negedge clk);
    end
    check("abort_reached", nw, 10);
    check("abort_data_live", (slice_out != 0) ? 1 : 0, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_write", write_file, 0);
    check("abort_slice", slice_out, 0);
    check("abort_index", line_index, 0);
    check("abort_busy", busy, 0);
    check("abort_read", read_file, 0);
    check("abort_finish", finish, 0);
    check("abort_state", state_dbg, 3'd0);
    #1 rst = 1'b0;
    for (int k = 0; k < 220; k++) begin
      @(negedge clk);
      if (finish || write_file || busy) nfin++;
    end
    check("abort_quiet", nfin, 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    fill(0);
    #12;
    check("rst_read", read_file, 0);
    check("rst_write", write_file, 0);
    check("rst_finish", finish, 0);
    check("rst_busy", busy, 0);
    check("rst_index", line_index, 0);
    check("rst_slice", slice_out, 0);
    check("rst_state", state_dbg, 3'd0);
    @(negedge clk);
    rst = 1'b0;

    // All-zero state.
    fill(0);
    run(1'b0);

    // Row-pair patterns with start spammed during the run.
    fill(1);
    run(1'b1);

    // Reset mid-run, then a clean restart from slice 0.
    fill(1);
    abort_run();
    fill(1);
    run(1'b0);

`ifdef CHI_BYPASS_EN
    chi_bypass = 1'b1;
    fill(2);
    run(1'b0);
    chi_bypass = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/chi_stage.md
CHI_STAGE -- requirements
Module: chi_stage

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  one-cycle request to process one full 64-slice state; sampled in IDLE only.
REQ-004 slice_in  input  25  slice addressed by line_index; driven by file/memory model; bit index = 5*y + x.
REQ-005 read_file  output  1  one-cycle pulse telling the file model to load the input state.
REQ-006 line_index  output  6  current slice number, 0..63.
REQ-007 write_file  output  1  one-cycle strobe: slice_out is valid for line_index.
REQ-008 slice_out  output  25  chi result for line_index.
REQ-009 finish  output  1  one-cycle pulse after slice 63 has been written.
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, INIT, READ, LOAD, CAL, WRITE, DONE.
REQ-012 Transitions: IDLE->INIT on start; INIT->READ; READ->LOAD; LOAD->CAL; CAL->WRITE; WRITE->DONE if counter==63, else LOAD; DONE->IDLE.
REQ-013 INIT SHALL pulse read_file and synchronously clear the slice counter.
REQ-014 LOAD SHALL register slice_in into the slice register.
REQ-015 CAL SHALL register chi(slice register) into the output register: out[5y+x] = in[5y+x] XOR (NOT in[5y+(x+1)%5] AND in[5y+(x+2)%5]).
REQ-016 WRITE SHALL assert write_file and increment the counter on the same edge that leaves WRITE.
REQ-017 slice_out SHALL hold the output register; it is valid whenever write_file is high.
REQ-018 line_index SHALL equal the counter in all states.
REQ-019 Counter wrap: after slice 63 the counter increments to 0 (6-bit wrap); no 65th write occurs.
REQ-020 Timing: start is sampled at edge E0. The first write_file is high in the cycle after edge E0+4. Writes then recur every 3 cycles. finish is high in the cycle after the 64th write.
REQ-021 start asserted outside IDLE SHALL be ignored; start held high through DONE SHALL begin a new run from IDLE.
REQ-022 read_file, write_file and finish SHALL be mutually exclusive and at most one cycle wide each.

Reset
REQ-023 rst SHALL immediately force IDLE, counter=0, slice and output registers=0, and all outputs low.
REQ-024 rst asserted mid-run SHALL abort the run with no finish pulse; the next start restarts at slice 0.

Configuration
REQ-025 With CHI_BYPASS_EN defined, a 1-bit input chi_bypass SHALL exist. When chi_bypass is high during CAL, the output register loads the slice register unchanged. FSM timing is unaffected.
REQ-026 Without CHI_BYPASS_EN, the chi_bypass port SHALL be absent and chi is always applied.

Structure
REQ-027 Package chi_pkg SHALL hold the state encoding (3-bit), SLICE_W=25, ROW_W=5, LINES=64 and IDX_W=6.
REQ-028 Sub-module chi_row SHALL implement the 5-bit combinational row function; chi_stage instantiates five copies (y=0..4).

Verification
REQ-029 slice_in=25'h0000000 for all slices -> 64 writes, each slice_out=25'h0000000, then one finish.
REQ-030 slice_in=25'h1FFFFFF -> slice_out=25'h1FFFFFF; slice_in=25'h0000002 -> 25'h0000012; slice_in=25'h0000004 -> 25'h0000005.
REQ-031 Timing: start at E0 -> read_file high in the cycle after E0; write_file high after E0+4, E0+7, ... E0+193; finish high after E0+194; line_index 0..63 in order.
REQ-032 rst pulsed after the 10th write -> all outputs low at once with no finish; a new start gives the first write with line_index=0.
REQ-033 start pulsed repeatedly during a run -> no extra read_file pulse and exactly 64 writes.
REQ-034 CHI_BYPASS_EN defined, chi_bypass=1, slice_in=25'h0000002 -> slice_out=25'h0000002.
